// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - request/response bus between an initiator and data_memory
interface data_memory_if;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;
    logic       ERROR;

    // Initiator side: raises a request and holds it until BUSYWAIT falls.
    modport master (
        output READ,
        output WRITE,
        output ADDRESS,
        output WRITEDATA,
        input  READDATA,
        input  BUSYWAIT,
        input  ERROR
    );

    // Memory side.
    modport slave (
        input  READ,
        input  WRITE,
        input  ADDRESS,
        input  WRITEDATA,
        output READDATA,
        output BUSYWAIT,
        output ERROR
    );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - 256 x 8 data memory with fixed multi-cycle access latency
module data_memory #(
    parameter int LATENCY = 5
) (
    input  logic          CLK,
    input  logic          RESET,
    data_memory_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // The accepting edge and the completing edge are both counted in
    // LATENCY, so the counter only has to cover the edges in between.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    logic [7:0] mem [256];

    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;
    logic [7:0] readdata_q;
    logic       error_q;

    logic       one_req;
    logic       both_req;
    logic       accept;
    logic       complete;
    logic       busy;

    // Request decode: exactly one request is legal, both at once is an error.
    always_comb begin
        one_req  = bus.READ ^ bus.WRITE;
        both_req = bus.READ & bus.WRITE;
    end

    // Next-state, counter and busy decode for the access sequencer.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                // Combinational so the initiator stalls in the request cycle.
                busy = one_req;
                if (one_req) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    complete   = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // One quiet cycle lets the initiator drop its request.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request at acceptance so bus changes mid-access are ignored.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= bus.ADDRESS;
            wdata_q <= bus.WRITEDATA;
            write_q <= bus.WRITE;
        end
    end

    // Read result register: only a completing read updates it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            readdata_q <= 8'h00;
        end else if (complete && !write_q) begin
            readdata_q <= mem[addr_q];
        end
    end

    // Illegal-request flag, high for the cycle after a both-high edge in IDLE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            error_q <= 1'b0;
        end else begin
            error_q <= (state == IDLE) && both_req;
        end
    end

    // Storage array; cleared by reset, so an aborted write never lands.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (complete && write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.READDATA = readdata_q;
    assign bus.ERROR    = error_q;
    assign bus.BUSYWAIT = busy & ~RESET;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - self-checking bench for data_memory at LATENCY 5 and 2
module tb_data_memory;

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    data_memory_if bus0 ();
    data_memory_if bus1 ();

    data_memory #(.LATENCY(5)) dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0));
    data_memory #(.LATENCY(2)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Transaction-level model: memory image plus expected visible outputs.
    logic [7:0] mdl [2][256];
    logic [7:0] exp_rd [2];
    bit         exp_busy [2];
    bit         exp_err [2];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input int inst, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
        if (inst == 0) begin
            bus0.READ = rd; bus0.WRITE = wr; bus0.ADDRESS = a; bus0.WRITEDATA = d;
        end else begin
            bus1.READ = rd; bus1.WRITE = wr; bus1.ADDRESS = a; bus1.WRITEDATA = d;
        end
    endtask

    task automatic set_addr(input int inst, input logic [7:0] a);
        if (inst == 0) bus0.ADDRESS = a;
        else           bus1.ADDRESS = a;
    endtask

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? bus0.BUSYWAIT : bus1.BUSYWAIT;
    endfunction

    function automatic logic [7:0] rd_of(input int inst);
        return (inst == 0) ? bus0.READDATA : bus1.READDATA;
    endfunction

    function automatic logic err_of(input int inst);
        return (inst == 0) ? bus0.ERROR : bus1.ERROR;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_rd[i]   = 8'h00;
            exp_busy[i] = 1'b0;
            exp_err[i]  = 1'b0;
            for (int j = 0; j < 256; j++) mdl[i][j] = 8'h00;
        end
    endtask

    // Every cycle, compare both instances against the model.
    always @(negedge CLK) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cyc_busy%0d", i), {7'b0, busy_of(i)}, {7'b0, exp_busy[i]});
                chk($sformatf("cyc_rd%0d", i), rd_of(i), exp_rd[i]);
                chk($sformatf("cyc_err%0d", i), {7'b0, err_of(i)}, {7'b0, exp_err[i]});
            end
        end
    end

    // One complete access; returns how many cycles BUSYWAIT was seen high,
    // including the RELEASE cycle, where it must already be low.
    task automatic access(input int inst, input bit wr, input logic [7:0] a,
                          input logic [7:0] d, input int chg_edge,
                          input logic [7:0] chg_addr, output int busy_cnt);
        int lat;
        lat = (inst == 0) ? 5 : 2;
        busy_cnt = 0;
        drive(inst, !wr, wr, a, d);
        exp_busy[inst] = 1'b1;
        for (int e = 1; e <= lat; e++) begin
            @(negedge CLK);
            if (busy_of(inst)) busy_cnt++;
            @(posedge CLK);
            #1;
            if (e == chg_edge) set_addr(inst, chg_addr);
            if (e == lat) begin
                if (wr) mdl[inst][a] = d;
                else    exp_rd[inst] = mdl[inst][a];
                exp_busy[inst] = 1'b0;
            end
        end
        @(negedge CLK);
        if (busy_of(inst)) busy_cnt++;
        #1;
        drive(inst, 1'b0, 1'b0, a, d);
        @(posedge CLK);
        #1;
    endtask

    int         bc;
    logic [7:0] pat;
    logic [7:0] cur;

    initial begin
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();

        // Reset with a read request already asserted.
        #2;
        RESET = 1'b1;
        drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check_en = 1'b1;
        chk("rst_busy", {7'b0, bus0.BUSYWAIT}, 8'h00);
        chk("rst_rd", bus0.READDATA, 8'h00);
        chk("rst_err", {7'b0, bus0.ERROR}, 8'h00);
        @(posedge CLK);
        #1;
        drive(0, 1'b0, 1'b0, 8'h10, 8'h00);
        RESET = 1'b0;

        // Read of an untouched location.
        access(0, 1'b0, 8'h10, 8'h00, 0, 8'h00, bc);
        chk("rd10_busy_len", 8'(bc), 8'd5);
        chk("rd10_data", bus0.READDATA, 8'h00);

        // Write then read back the top address.
        access(0, 1'b1, 8'hFF, 8'h5A, 0, 8'h00, bc);
        chk("wrFF_busy_len", 8'(bc), 8'd5);
        access(0, 1'b0, 8'hFF, 8'h00, 0, 8'h00, bc);
        chk("rdFF_busy_len", 8'(bc), 8'd5);
        chk("rdFF_data", bus0.READDATA, 8'h5A);

        // Writes leave READDATA alone; bottom address does not alias the top.
        access(0, 1'b1, 8'h20, 8'hA5, 0, 8'h00, bc);
        access(0, 1'b1, 8'h21, 8'h3C, 0, 8'h00, bc);
        access(0, 1'b1, 8'h00, 8'hE1, 0, 8'h00, bc);
        chk("rd_held_over_writes", bus0.READDATA, 8'h5A);

        // Address moved mid-access must not redirect the read.
        access(0, 1'b0, 8'h20, 8'h00, 2, 8'h21, bc);
        chk("rd20_addr_change", bus0.READDATA, 8'hA5);
        access(0, 1'b0, 8'h00, 8'h00, 0, 8'h00, bc);
        chk("rd00_data", bus0.READDATA, 8'hE1);
        access(0, 1'b0, 8'hFF, 8'h00, 0, 8'h00, bc);
        chk("rdFF_no_alias", bus0.READDATA, 8'h5A);

        // Both requests high: no stall, one ERROR pulse, memory untouched.
        access(0, 1'b1, 8'h40, 8'h11, 0, 8'h00, bc);
        drive(0, 1'b1, 1'b1, 8'h40, 8'h99);
        exp_busy[0] = 1'b0;
        @(negedge CLK);
        chk("both_busy", {7'b0, bus0.BUSYWAIT}, 8'h00);
        @(posedge CLK);
        #1;
        exp_err[0] = 1'b1;
        chk("err_pulse", {7'b0, bus0.ERROR}, 8'h01);
        drive(0, 1'b0, 1'b0, 8'h40, 8'h99);
        @(posedge CLK);
        #1;
        exp_err[0] = 1'b0;
        chk("err_clear", {7'b0, bus0.ERROR}, 8'h00);
        access(0, 1'b0, 8'h40, 8'h00, 0, 8'h00, bc);
        chk("rd40_unchanged", bus0.READDATA, 8'h11);

        // Reset in the middle of a write aborts it immediately.
        drive(0, 1'b0, 1'b1, 8'h03, 8'h77);
        exp_busy[0] = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        chk("rst_abort_busy", {7'b0, bus0.BUSYWAIT}, 8'h00);
        chk("rst_abort_rd", bus0.READDATA, 8'h00);
        model_reset();
        @(posedge CLK);
        #1;
        drive(0, 1'b0, 1'b0, 8'h03, 8'h00);
        RESET = 1'b0;
        access(0, 1'b0, 8'h03, 8'h00, 0, 8'h00, bc);
        chk("rd03_after_abort", bus0.READDATA, 8'h00);
        chk("rd03_busy_len", 8'(bc), 8'd5);
        access(0, 1'b0, 8'hFF, 8'h00, 0, 8'h00, bc);
        chk("rdFF_after_reset", bus0.READDATA, 8'h00);

        // LATENCY 2 instance: preload, then hold READ across RELEASE.
        access(1, 1'b1, 8'h08, 8'hC3, 0, 8'h00, bc);
        chk("l2_wr_busy_len", 8'(bc), 8'd2);
        access(1, 1'b1, 8'h09, 8'h3C, 0, 8'h00, bc);
        access(1, 1'b1, 8'h0A, 8'h81, 0, 8'h00, bc);
        cur = 8'h08;
        pat = 8'h00;
        drive(1, 1'b1, 1'b0, cur, 8'h00);
        exp_busy[1] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge CLK);
            pat[n-1] = bus1.BUSYWAIT;
            @(posedge CLK);
            #1;
            case (n % 3)
                1: exp_busy[1] = 1'b1;
                2: begin
                    exp_rd[1]   = mdl[1][cur];
                    exp_busy[1] = 1'b0;
                    cur = cur + 8'd1;
                    if (n != 8) set_addr(1, cur);
                end
                default: exp_busy[1] = 1'b1;
            endcase
            if (n == 2) chk("l2_first_rd", bus1.READDATA, 8'hC3);
            if (n == 5) chk("l2_second_rd", bus1.READDATA, 8'h3C);
        end
        drive(1, 1'b0, 1'b0, cur, 8'h00);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("l2_busy_pattern", pat, 8'b11011011);
        chk("l2_third_rd", bus1.READDATA, 8'h81);
        @(negedge CLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
